// File: rtl/nf10_rate_limiter_pkg.sv
// nf10_rate_limiter_pkg
//   Shared definitions for the packet-granular token-bucket policer.
//   - state_e      : packet-walk FSM states (SOP, PASS, DROP)
//   - TUSER_LEN_*  : position of the packet byte length inside tuser
//   - LEN_WIDTH    : width of that length field
package nf10_rate_limiter_pkg;

   typedef enum logic [1:0] {
      SOP  = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_e;

   localparam int TUSER_LEN_LSB = 0;
   localparam int TUSER_LEN_MSB = 15;
   localparam int LEN_WIDTH     = TUSER_LEN_MSB - TUSER_LEN_LSB + 1;

endpackage

// File: rtl/nf10_rate_limiter_token_bucket.sv
// token_bucket
//   Byte-granular refilling bucket. Every cycle the level becomes
//   min(tokens - deduct + rate_inc, burst_size), evaluated one bit wider
//   than the bucket so the refill can never wrap before the clamp.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (level -> 0)
//   rate_inc      bytes added every cycle
//   burst_size    bucket ceiling; lowering it clamps the level next cycle
//   deduct_en     subtract deduct_len this cycle
//   deduct_len    packet length in bytes
//   tokens        current level
//   ok            tokens >= deduct_len (combinational, uses current level)
//
// deduct_en must only be raised while ok is high; the caller guarantees
// this, so the subtraction never underflows.
module token_bucket
   import nf10_rate_limiter_pkg::*;
#(
   parameter int TOKEN_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            rate_inc,
   input  logic [TOKEN_WIDTH-1:0] burst_size,
   input  logic                   deduct_en,
   input  logic [LEN_WIDTH-1:0]   deduct_len,
   output logic [TOKEN_WIDTH-1:0] tokens,
   output logic                   ok
);

   localparam int SUM_W = TOKEN_WIDTH + 1;

   logic [SUM_W-1:0]       sum;
   logic [SUM_W-1:0]       ceiling;
   logic [TOKEN_WIDTH-1:0] tokens_next;

   always_comb begin
      sum = {1'b0, tokens} + SUM_W'(rate_inc);
      if (deduct_en) begin
         sum = sum - SUM_W'(deduct_len);
      end
      ceiling     = {1'b0, burst_size};
      tokens_next = (sum > ceiling) ? burst_size : sum[TOKEN_WIDTH-1:0];
   end

   assign ok = ({1'b0, tokens} >= SUM_W'(deduct_len));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tokens <= '0;
      end else begin
         tokens <= tokens_next;
      end
   end

endmodule

// File: rtl/nf10_rate_limiter.sv
// nf10_rate_limiter
//   Packet-granular token-bucket policer between the filter stage and the
//   output queues. The SOP beat's tuser[15:0] length is compared with the
//   bucket level; the whole packet is then forwarded (PASS) or drained (DROP).
//   Forwarded beats go through a one-deep output register (1-cycle latency,
//   full throughput).
//
// Ports:
//   axi_aclk, axi_aresetn   clock, asynchronous active-low reset
//   s_axis_*                upstream AXI-Stream slave
//   m_axis_*                downstream AXI-Stream master
//   policer_en              0 = admit everything (bucket still refills)
//   rate_inc                bytes added to the bucket per cycle
//   burst_size              bucket ceiling in bytes
//   pass_pkts, drop_pkts    admitted / dropped packet counters (wrap at 2^32)
//   tokens                  current bucket level
//
// Build option: define NF10_RATE_LIMITER_STATS_EN to get live packet
// counters; otherwise pass_pkts/drop_pkts are tied to 0 and no counter
// registers exist.
//
// Handshake: a beat transfers on a cycle where valid && ready are both high
// at the rising clock edge; valid never waits on ready, and a master holds
// its payload stable while valid && !ready. Upstream ready is the output
// register's free condition, except while draining a dropped packet (DROP
// state, or a SOP beat being dropped) where ready is forced high.
module nf10_rate_limiter
   import nf10_rate_limiter_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int TOKEN_WIDTH          = 24
) (
   input  logic                              axi_aclk,
   input  logic                              axi_aresetn,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,

   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,

   input  logic                              policer_en,
   input  logic [15:0]                       rate_inc,
   input  logic [TOKEN_WIDTH-1:0]            burst_size,
   output logic [31:0]                       pass_pkts,
   output logic [31:0]                       drop_pkts,
   output logic [TOKEN_WIDTH-1:0]            tokens
);

   state_e                 state;
   state_e                 state_next;

   logic [LEN_WIDTH-1:0]   pkt_len;
   logic                   bucket_ok;
   logic                   admit;
   logic                   out_free;
   logic                   sop_drop;
   logic                   beat;
   logic                   sop_beat;
   logic                   fwd_beat;
   logic                   deduct_en;

   assign pkt_len  = s_axis_tuser[TUSER_LEN_MSB:TUSER_LEN_LSB];

   // len=0 is always admitted because ok compares tokens >= 0.
   assign admit    = !policer_en || bucket_ok;

   assign out_free = !m_axis_tvalid || m_axis_tready;
   assign sop_drop = (state == SOP) && s_axis_tvalid && !admit;

   assign s_axis_tready = (state == DROP) || sop_drop || out_free;

   assign beat      = s_axis_tvalid && s_axis_tready;
   assign sop_beat  = beat && (state == SOP);
   assign fwd_beat  = beat && ((state == PASS) || ((state == SOP) && admit));
   assign deduct_en = sop_beat && admit && policer_en;

   token_bucket #(
      .TOKEN_WIDTH (TOKEN_WIDTH)
   ) u_bucket (
      .clk        (axi_aclk),
      .rst_n      (axi_aresetn),
      .rate_inc   (rate_inc),
      .burst_size (burst_size),
      .deduct_en  (deduct_en),
      .deduct_len (pkt_len),
      .tokens     (tokens),
      .ok         (bucket_ok)
   );

   // Packet-walk FSM: the decision is only taken in SOP; a single-beat
   // packet never leaves SOP.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state <= SOP;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         SOP: begin
            if (beat && !s_axis_tlast) begin
               state_next = admit ? PASS : DROP;
            end
         end
         PASS, DROP: begin
            if (beat && s_axis_tlast) begin
               state_next = SOP;
            end
         end
         default: state_next = SOP;
      endcase
   end

   // One-deep output register. It only changes when empty or being drained,
   // which keeps m_axis_* stable under backpressure.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
      end else if (out_free) begin
         m_axis_tvalid <= fwd_beat;
         if (fwd_beat) begin
            m_axis_tlast <= s_axis_tlast;
            m_axis_tdata <= s_axis_tdata;
            m_axis_tstrb <= s_axis_tstrb;
            m_axis_tuser <= s_axis_tuser;
         end
      end
   end

`ifdef NF10_RATE_LIMITER_STATS_EN
   logic [31:0] pass_cnt;
   logic [31:0] drop_cnt;

   // One count per packet, taken on its SOP beat.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         pass_cnt <= '0;
         drop_cnt <= '0;
      end else if (sop_beat) begin
         if (admit) begin
            pass_cnt <= pass_cnt + 32'd1;
         end else begin
            drop_cnt <= drop_cnt + 32'd1;
         end
      end
   end

   assign pass_pkts = pass_cnt;
   assign drop_pkts = drop_cnt;
`else
   assign pass_pkts = '0;
   assign drop_pkts = '0;
`endif

endmodule

// File: tb/tb_nf10_rate_limiter.sv
// tb_nf10_rate_limiter
//   Directed scenarios followed by randomized packets. A behavioural model
//   (integer bucket, per-packet admit flag, one-slot output buffer and an
//   expected-beat queue) predicts every cycle's upstream ready, output
//   register contents, bucket level and packet counters.
module tb_nf10_rate_limiter;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = DW / 8;
   localparam int TW = 24;

`ifdef NF10_RATE_LIMITER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [DW-1:0] s_axis_tdata;
   logic [SW-1:0] s_axis_tstrb;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [SW-1:0] m_axis_tstrb;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;
   logic          policer_en;
   logic [15:0]   rate_inc;
   logic [TW-1:0] burst_size;
   logic [31:0]   pass_pkts;
   logic [31:0]   drop_pkts;
   logic [TW-1:0] tokens;

   nf10_rate_limiter #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .TOKEN_WIDTH          (TW)
   ) dut (
      .axi_aclk      (clk),
      .axi_aresetn   (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .policer_en    (policer_en),
      .rate_inc      (rate_inc),
      .burst_size    (burst_size),
      .pass_pkts     (pass_pkts),
      .drop_pkts     (drop_pkts),
      .tokens        (tokens)
   );

   // ---------------- scoreboard / model state ----------------
   int            checks = 0;
   int            errors = 0;

   int            mt;          // bucket level in bytes
   bit            in_pkt;      // inside a multi-beat packet
   bit            pkt_pass;    // current packet was admitted
   bit            slot_full;   // output register holds a beat
   logic [DW-1:0] slot_data;
   logic [SW-1:0] slot_strb;
   logic [UW-1:0] slot_user;
   logic          slot_last;
   logic [31:0]   m_pass;
   logic [31:0]   m_drop;
   logic [DW-1:0] exp_q[$];

   bit            last_acc;
   int            pkt_steps;
   bit            rand_rdy;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mt        = 0;
      in_pkt    = 0;
      pkt_pass  = 0;
      slot_full = 0;
      m_pass    = '0;
      m_drop    = '0;
      exp_q.delete();
   endtask

   // One clock cycle: check at the falling edge, advance the model at the
   // rising edge, return 1 time unit later so the caller can drive inputs.
   task automatic step();
      int            len;
      int            ded;
      bit            adm;
      bit            draining;
      bit            rdy;
      bit            acc;
      bit            fwd;
      logic [DW-1:0] exp_d;
      @(negedge clk);
      len = int'(s_axis_tuser[15:0]);
      adm = !policer_en || (mt >= len);
      if (!in_pkt) draining = s_axis_tvalid && !adm;
      else         draining = !pkt_pass;
      rdy = draining || !slot_full || m_axis_tready;
      chk("s_tready", s_axis_tready, rdy);
      chk("m_tvalid", m_axis_tvalid, slot_full);
      if (slot_full) begin
         chk("m_tdata", m_axis_tdata, slot_data);
         chk("m_tstrb", m_axis_tstrb, slot_strb);
         chk("m_tuser", m_axis_tuser, slot_user);
         chk("m_tlast", m_axis_tlast, slot_last);
      end
      if (slot_full && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 1'b1, 1'b0);
         end else begin
            exp_d = exp_q.pop_front();
            chk("sb_data", m_axis_tdata, exp_d);
         end
      end
      chk("tokens", tokens, TW'(mt));
      chk("pass_pkts", pass_pkts, STATS ? m_pass : 32'd0);
      chk("drop_pkts", drop_pkts, STATS ? m_drop : 32'd0);
      acc = s_axis_tvalid && rdy;
      fwd = acc && (in_pkt ? pkt_pass : adm);

      @(posedge clk);
      ded = 0;
      if (slot_full && m_axis_tready) slot_full = 0;
      if (acc) begin
         if (!in_pkt) begin
            if (adm) begin
               m_pass++;
               if (policer_en) ded = len;
            end else begin
               m_drop++;
            end
            pkt_pass = adm;
         end
         in_pkt = !s_axis_tlast;
      end
      if (fwd) begin
         slot_full = 1;
         slot_data = s_axis_tdata;
         slot_strb = s_axis_tstrb;
         slot_user = s_axis_tuser;
         slot_last = s_axis_tlast;
         exp_q.push_back(s_axis_tdata);
      end
      mt = mt - ded + int'(rate_inc);
      if (mt > int'(burst_size)) mt = int'(burst_size);
      last_acc = acc;
      #1;
   endtask

   task automatic do_reset();
      s_axis_tvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_m_tlast", m_axis_tlast, 1'b0);
      chk("rst_m_tdata", m_axis_tdata, '0);
      chk("rst_m_tstrb", m_axis_tstrb, '0);
      chk("rst_m_tuser", m_axis_tuser, '0);
      chk("rst_tokens", tokens, '0);
      chk("rst_pass", pass_pkts, '0);
      chk("rst_drop", drop_pkts, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Drive one packet (or its first nsend beats). stall_at >= 0 holds
   // m_axis_tready low for 5 cycles while presenting that beat.
   task automatic send_pkt(input int nbeats, input int len, input int stall_at,
                           input bit gaps, input int nsend);
      int stall_acc;
      int guard;
      pkt_steps = 0;
      for (int b = 0; b < nsend; b++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            step();
         end
         s_axis_tvalid = 1'b1;
         for (int k = 0; k < DW / 32; k++) s_axis_tdata[k*32 +: 32] = $urandom();
         s_axis_tstrb = $urandom();
         s_axis_tuser = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (b == 0) s_axis_tuser[15:0] = 16'(len);
         s_axis_tlast = (b == nbeats - 1);
         if (b == stall_at) begin
            m_axis_tready = 1'b0;
            stall_acc = 0;
            repeat (5) begin
               step();
               pkt_steps++;
               stall_acc += int'(last_acc);
            end
            chk("bp_no_accept", 32'(stall_acc), 32'd0);
            m_axis_tready = 1'b1;
         end
         guard = 0;
         do begin
            if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
            step();
            pkt_steps++;
            guard++;
         end while (!last_acc && guard < 50);
         chk("accept_timeout", last_acc, 1'b1);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tuser  = '0;
      m_axis_tready = 1'b1;
      policer_en    = 1'b1;
      rate_inc      = 16'd0;
      burst_size    = 24'd1000;
      rand_rdy      = 1'b0;
      model_reset();
      #2;
      do_reset();

      // Refill to the ceiling and hold there.
      rate_inc = 16'd10;
      repeat (100) step();
      chk("refill_full", tokens, 24'd1000);
      repeat (5) step();
      chk("refill_hold", tokens, 24'd1000);

      // Admit 600 of 1000, then drop the next 600.
      rate_inc = 16'd0;
      send_pkt(3, 600, -1, 1'b0, 3);
      send_pkt(3, 600, -1, 1'b0, 3);
      repeat (2) step();
      chk("ad_tokens", tokens, 24'd400);
      chk("ad_pass", pass_pkts, STATS ? 32'd1 : 32'd0);
      chk("ad_drop", drop_pkts, STATS ? 32'd1 : 32'd0);

      // Backpressure mid-packet on an admitted packet.
      send_pkt(4, 100, 2, 1'b0, 4);
      repeat (2) step();
      chk("bp_tokens", tokens, 24'd300);

      // Drop with downstream stalled: drained one beat per cycle.
      m_axis_tready = 1'b0;
      send_pkt(4, 1500, -1, 1'b0, 4);
      chk("drop_drain_cycles", 32'(pkt_steps), 32'd4);
      m_axis_tready = 1'b1;
      repeat (2) step();

      // Policer disabled with an empty bucket.
      do_reset();
      policer_en = 1'b0;
      send_pkt(2, 1500, -1, 1'b0, 2);
      repeat (2) step();
      chk("dis_tokens", tokens, 24'd0);
      chk("dis_pass", pass_pkts, STATS ? 32'd1 : 32'd0);
      policer_en = 1'b1;

      // Refill and deduct on the same cycle.
      rate_inc = 16'd50;
      repeat (2) step();
      chk("sim_pre", tokens, 24'd100);
      send_pkt(1, 100, -1, 1'b0, 1);
      chk("sim_tokens", tokens, 24'd50);
      chk("sim_pass", pass_pkts, STATS ? 32'd2 : 32'd0);

      // Reset mid-packet; the tail becomes a new len=0 packet.
      policer_en = 1'b0;
      send_pkt(4, 64, -1, 1'b0, 2);
      do_reset();
      policer_en = 1'b1;
      rate_inc   = 16'd0;
      send_pkt(2, 0, -1, 1'b0, 2);
      repeat (2) step();
      chk("len0_pass", pass_pkts, STATS ? 32'd1 : 32'd0);
      chk("len0_tokens", tokens, 24'd0);

      // Randomized traffic.
      rand_rdy = 1'b1;
      for (int p = 0; p < 60; p++) begin
         int nb;
         int ln;
         rate_inc = 16'($urandom_range(0, 40));
         if ($urandom_range(0, 9) == 0) burst_size = 24'($urandom_range(200, 3000));
         policer_en = ($urandom_range(0, 9) != 0);
         nb = $urandom_range(1, 5);
         ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1500);
         send_pkt(nb, ln, -1, 1'b1, nb);
      end
      rand_rdy      = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) step();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
